alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 163 ++++++++++++++++
 tb/tb_alu_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: 16-bit multi-cycle ALU with start/busy/done handshake.
// Define ALU_CORE_MUL_EN to build the 16-cycle shift-add multiplier.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [15:0] alu_out,
  output logic        z_flag,
  output logic        c_flag,
  output logic        busy,
  output logic        done
);

`ifdef ALU_CORE_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
`endif

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] out_q, out_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic        done_q, done_d;
  logic [15:0] res;
  logic        cy;

`ifdef ALU_CORE_MUL_EN
  logic [31:0] prod_q, prod_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] sum;

  // Upper half accumulates the multiplicand; lower half holds the multiplier.
  assign sum = {1'b0, prod_q[31:16]}
             + (prod_q[0] ? {1'b0, a_q} : 17'h0);
`endif

  always_comb begin
    res = 16'h0000;
    cy  = 1'b0;
    unique case (op_q)
      OP_PASS: res = b_q;
      OP_ADD:  {cy, res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        res = a_q - b_q;
        cy  = (a_q < b_q);
      end
      OP_INC:  {cy, res} = {1'b0, a_q} + 17'd1;
`ifdef ALU_CORE_MUL_EN
      OP_MUL: begin
        res = prod_q[15:0];
        cy  = |prod_q[31:16];
      end
`else
      OP_MUL:  res = a_q;
`endif
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_SHR: begin
        res = {1'b0, a_q[15:1]};
        cy  = a_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    done_d  = 1'b0;
`ifdef ALU_CORE_MUL_EN
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          state_d = EXEC;
`ifdef ALU_CORE_MUL_EN
          prod_d  = {16'h0000, b_in};
          cnt_d   = 4'd0;
          if (op == OP_MUL) state_d = MULT;
`endif
        end
      end
      EXEC: state_d = DONE;
`ifdef ALU_CORE_MUL_EN
      MULT: begin
        prod_d = {sum, prod_q[15:1]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'hF) state_d = DONE;
      end
`endif
      DONE: begin
        out_d   = res;
        z_d     = (res == 16'h0000);
        c_d     = cy;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      out_q   <= 16'h0000;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_CORE_MUL_EN
      prod_q  <= 32'h0;
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      done_q  <= done_d;
`ifdef ALU_CORE_MUL_EN
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign alu_out = out_q;
  assign z_flag  = z_q;
  assign c_flag  = c_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core.
// Expected results are queued at issue and popped on each done pulse.
module tb_alu_core;

  typedef struct {
    logic [15:0] out;
    logic        z;
    logic        c;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] a_in = 16'h0;
  logic [15:0] b_in = 16'h0;
  logic [15:0] alu_out;
  logic        z_flag;
  logic        c_flag;
  logic        busy;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  alu_core dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .alu_out(alu_out),
    .z_flag(z_flag), .c_flag(c_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        chk("alu_out", {16'h0, alu_out}, {16'h0, e.out});
        chk("z_flag", {31'h0, z_flag}, {31'h0, e.z});
        chk("c_flag", {31'h0, c_flag}, {31'h0, e.c});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [15:0] eo, input logic ez,
                      input logic ec, input int at);
    exp_t e;
    e.out = eo;
    e.z   = ez;
    e.c   = ec;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eo,
                       input logic ez, input logic ec, input int lat);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    push(eo, ez, ec, cyc + 1 + lat);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_out"}, {16'h0, alu_out}, 32'h0);
    chk({t, "_z"}, {31'h0, z_flag}, 32'h1);
    chk({t, "_c"}, {31'h0, c_flag}, 32'h0);
    chk({t, "_busy"}, {31'h0, busy}, 32'h0);
    chk({t, "_done"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");

    issue(3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 2);
    drain(10);
    issue(3'b010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 2);
    drain(10);
    issue(3'b001, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 2);
    drain(10);
    issue(3'b000, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 2);
    drain(10);
    issue(3'b011, 16'hFFFF, 16'h7777, 16'h0000, 1'b1, 1'b1, 2);
    drain(10);
    issue(3'b101, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 2);
    drain(10);
    issue(3'b110, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 2);
    drain(10);
    issue(3'b111, 16'h8001, 16'h0000, 16'h4000, 1'b0, 1'b1, 2);
    drain(10);

`ifdef ALU_CORE_MUL_EN
    issue(3'b100, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 17);
    drain(40);
    issue(3'b100, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0, 17);
    drain(40);
`else
    issue(3'b100, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0, 2);
    drain(10);
`endif

    // Start held through EXEC and DONE with different operands: ignored.
    @(negedge clk);
    start = 1'b1; op = 3'b001; a_in = 16'h0010; b_in = 16'h0020;
    push(16'h0030, 1'b0, 1'b0, cyc + 3);
    @(negedge clk);
    op = 3'b010; a_in = 16'hFFFF; b_in = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain(10);
    repeat (6) @(negedge clk);

    // Back-to-back: operand change after capture feeds only the second op.
    @(negedge clk);
    start = 1'b1; op = 3'b001; a_in = 16'h0001; b_in = 16'h0001;
    push(16'h0002, 1'b0, 1'b0, cyc + 3);
    push(16'h0006, 1'b0, 1'b0, cyc + 6);
    @(negedge clk);
    a_in = 16'h0005;
    repeat (4) @(negedge clk);
    start = 1'b0;
    drain(20);
    repeat (4) @(negedge clk);

    // Reset during EXEC aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 3'b001; a_in = 16'h1111; b_in = 16'h2222;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("abort_exec");
    repeat (6) @(negedge clk);
    issue(3'b001, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 2);
    drain(10);

`ifdef ALU_CORE_MUL_EN
    // Mid-MULT operand change and start pulse are ignored.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a_in = 16'h0007; b_in = 16'h0009;
    push(16'h003F, 1'b0, 1'b0, cyc + 18);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b001; b_in = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (20) @(negedge clk);

    // Reset at MULT cycle 8 aborts the multiply.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a_in = 16'h0100; b_in = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("abort_mult");
    repeat (20) @(negedge clk);
    issue(3'b001, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 2);
    drain(10);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
